// File: rtl/sid_pkg.sv
// Shared constants for the SID voice register front end: register offsets,
// access FSM states and control-register bit positions.
package sid_pkg;

    localparam logic [2:0] REG_FREQ_LO = 3'd0;
    localparam logic [2:0] REG_FREQ_HI = 3'd1;
    localparam logic [2:0] REG_PW_LO   = 3'd2;
    localparam logic [2:0] REG_PW_HI   = 3'd3;
    localparam logic [2:0] REG_CTRL    = 3'd4;
    localparam logic [2:0] REG_AD      = 3'd5;
    localparam logic [2:0] REG_SR      = 3'd6;

    localparam int VOICE_REGS = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam int GATE  = 0;
    localparam int SYNC  = 1;
    localparam int RING  = 2;
    localparam int TEST  = 3;
    localparam int TRI   = 4;
    localparam int SAW   = 5;
    localparam int PULSE = 6;
    localparam int NOISE = 7;

endpackage

// File: rtl/sid_sync.sv
// N-stage flip-flop synchronizer for a group of asynchronous inputs.
// Latency STAGES clk; no backpressure. Reset loads RST_VAL into every stage.
module sid_sync #(
    parameter int                WIDTH   = 1,
    parameter int                STAGES  = 2,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/sid_voice_regs.sv
// Bus write decoder for one SID voice; freq/pw commit atomically from LO shadows.
// Latency SYNC_STAGES+1 clk from cs_n rise to register update; no backpressure.
module sid_voice_regs
    import sid_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR   = 5'd0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        rw,
    input  logic [4:0]  addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [15:0] freq,
    output logic [11:0] pw,
    output logic [7:0]  control,
    output logic [7:0]  attack_decay,
    output logic [7:0]  sustain_release,
    output logic        update
);

    logic       cs_s, rw_s;
    logic [4:0] addr_s;
    logic [7:0] data_s;

    sid_sync #(.WIDTH(2), .STAGES(SYNC_STAGES), .RST_VAL(2'b11)) u_sync_ctl (
        .clk (clk),
        .rst (rst),
        .d   ({cs_n, rw}),
        .q   ({cs_s, rw_s})
    );

    sid_sync #(.WIDTH(13), .STAGES(SYNC_STAGES), .RST_VAL(13'd0)) u_sync_bus (
        .clk (clk),
        .rst (rst),
        .d   ({addr, data_in}),
        .q   ({addr_s, data_s})
    );

    state_t     state;
    logic       cs_prev;
    logic       rw_lat;
    logic [2:0] off_lat;
    logic       rise_pend;
    logic [7:0] freq_lo;
    logic [7:0] pw_lo;

    logic       cs_fall, cs_rise, hit;
    logic [5:0] offset_full;

    assign cs_fall = cs_prev & ~cs_s;
    assign cs_rise = ~cs_prev & cs_s;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign offset_full = {1'b0, addr_s} - {1'b0, BASE_ADDR};
    assign hit         = offset_full < 6'(VOICE_REGS);

    // Every register of a voice is write-only and reads back as zero.
    assign data_out = 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cs_prev         <= 1'b1;
            rw_lat          <= 1'b0;
            off_lat         <= 3'd0;
            rise_pend       <= 1'b0;
            freq_lo         <= 8'd0;
            pw_lo           <= 8'd0;
            data_oe         <= 1'b0;
            freq            <= 16'd0;
            pw              <= 12'd0;
            control         <= 8'd0;
            attack_decay    <= 8'd0;
            sustain_release <= 8'd0;
            update          <= 1'b0;
        end else begin
            cs_prev <= cs_s;
            update  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall && hit) begin
                        state     <= ACCESS;
                        rw_lat    <= rw_s;
                        off_lat   <= offset_full[2:0];
                        data_oe   <= rw_s;
                        rise_pend <= 1'b0;
                    end
                end
                ACCESS: begin
                    // A very short cs_n pulse can rise before WAIT; remember it.
                    if (cs_rise) rise_pend <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cs_rise || rise_pend) begin
                        rise_pend <= 1'b0;
                        data_oe   <= 1'b0;
                        state     <= IDLE;
                        if (!rw_lat) begin
                            case (off_lat)
                                REG_FREQ_LO: freq_lo <= data_s;
                                REG_FREQ_HI: begin
                                    freq   <= {data_s, freq_lo};
                                    update <= 1'b1;
                                end
                                REG_PW_LO:   pw_lo <= data_s;
                                REG_PW_HI: begin
                                    pw     <= {data_s[3:0], pw_lo};
                                    update <= 1'b1;
                                end
                                REG_CTRL:    control         <= data_s;
                                REG_AD:      attack_decay    <= data_s;
                                REG_SR:      sustain_release <= data_s;
                                default:     ;
                            endcase
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sid_voice_regs.sv
// Two voices (base 0 and base 7) on a shared bus, driven by directed and
// random bus cycles and compared against a per-voice register-map model.
module tb_sid_voice_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n, rw;
    logic [4:0] addr;
    logic [7:0] data_in;

    logic [7:0]  dout0, dout1, ctl0, ctl1, ad0, ad1, sr0, sr1;
    logic        oe0, oe1, upd0, upd1;
    logic [15:0] freq0, freq1;
    logic [11:0] pw0, pw1;

    always #5 clk = ~clk;

    sid_voice_regs #(.BASE_ADDR(5'd0), .SYNC_STAGES(2)) u_v0 (
        .clk(clk), .rst(rst), .cs_n(cs_n), .rw(rw), .addr(addr), .data_in(data_in),
        .data_out(dout0), .data_oe(oe0), .freq(freq0), .pw(pw0), .control(ctl0),
        .attack_decay(ad0), .sustain_release(sr0), .update(upd0)
    );

    sid_voice_regs #(.BASE_ADDR(5'd7), .SYNC_STAGES(3)) u_v1 (
        .clk(clk), .rst(rst), .cs_n(cs_n), .rw(rw), .addr(addr), .data_in(data_in),
        .data_out(dout1), .data_oe(oe1), .freq(freq1), .pw(pw1), .control(ctl1),
        .attack_decay(ad1), .sustain_release(sr1), .update(upd1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Update pulses observed per voice, plus back-to-back occurrences.
    int seen_upd [2] = '{0, 0};
    int dbl_upd  [2] = '{0, 0};
    logic prev0 = 1'b0, prev1 = 1'b0;
    always @(negedge clk) begin
        if (upd0) seen_upd[0] <= seen_upd[0] + 1;
        if (upd1) seen_upd[1] <= seen_upd[1] + 1;
        if (upd0 && prev0) dbl_upd[0] <= dbl_upd[0] + 1;
        if (upd1 && prev1) dbl_upd[1] <= dbl_upd[1] + 1;
        prev0 <= upd0;
        prev1 <= upd1;
    end

    // Reference model: register-map semantics per voice.
    int         base [2] = '{0, 7};
    logic [7:0]  m_flo [2], m_plo [2], m_ctl [2], m_ad [2], m_sr [2];
    logic [15:0] m_freq [2];
    logic [11:0] m_pw [2];
    int          m_upd [2] = '{0, 0};

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_flo[v] = 0; m_plo[v] = 0; m_ctl[v] = 0; m_ad[v] = 0; m_sr[v] = 0;
            m_freq[v] = 0; m_pw[v] = 0;
        end
    endtask

    task automatic model_write(input int a, input logic [7:0] d);
        for (int v = 0; v < 2; v++) begin
            if (a >= base[v] && a <= base[v] + 6) begin
                case (a - base[v])
                    0: m_flo[v] = d;
                    1: begin m_freq[v] = m_freq[v] & 16'h0000 | (16'(d) * 256 + 16'(m_flo[v])); m_upd[v]++; end
                    2: m_plo[v] = d;
                    3: begin m_pw[v] = 12'((d % 16) * 256 + m_plo[v]); m_upd[v]++; end
                    4: m_ctl[v] = d;
                    5: m_ad[v]  = d;
                    default: m_sr[v] = d;
                endcase
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " v0 freq"}, 32'(freq0), 32'(m_freq[0]));
        check({tag, " v0 pw"},   32'(pw0),   32'(m_pw[0]));
        check({tag, " v0 ctl"},  32'(ctl0),  32'(m_ctl[0]));
        check({tag, " v0 ad"},   32'(ad0),   32'(m_ad[0]));
        check({tag, " v0 sr"},   32'(sr0),   32'(m_sr[0]));
        check({tag, " v0 oe"},   32'(oe0),   32'd0);
        check({tag, " v0 upd"},  32'(seen_upd[0]), 32'(m_upd[0]));
        check({tag, " v1 freq"}, 32'(freq1), 32'(m_freq[1]));
        check({tag, " v1 pw"},   32'(pw1),   32'(m_pw[1]));
        check({tag, " v1 ctl"},  32'(ctl1),  32'(m_ctl[1]));
        check({tag, " v1 ad"},   32'(ad1),   32'(m_ad[1]));
        check({tag, " v1 sr"},   32'(sr1),   32'(m_sr[1]));
        check({tag, " v1 oe"},   32'(oe1),   32'd0);
        check({tag, " v1 upd"},  32'(seen_upd[1]), 32'(m_upd[1]));
    endtask

    task automatic bus_write(input int a, input logic [7:0] d, input int low);
        @(negedge clk);
        addr = 5'(a); rw = 1'b0; data_in = d;
        #2 cs_n = 1'b0;
        repeat (low) @(negedge clk);
        #1 cs_n = 1'b1;
        repeat (9) @(negedge clk);
        model_write(a, d);
    endtask

    task automatic bus_read(input int a, input int low);
        @(negedge clk);
        addr = 5'(a); rw = 1'b1; data_in = 8'($urandom);
        #2 cs_n = 1'b0;
        repeat (6) @(negedge clk);
        check("read oe v0", 32'(oe0), 32'(a >= 0 && a <= 6));
        check("read oe v1", 32'(oe1), 32'(a >= 7 && a <= 13));
        check("read data v0", 32'(dout0), 32'h0);
        check("read data v1", 32'(dout1), 32'h0);
        repeat (low - 6) @(negedge clk);
        #1 cs_n = 1'b1;
        repeat (9) @(negedge clk);
        rw = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cs_n = 1'b1; rw = 1'b0; addr = 5'd0; data_in = 8'd0;
        model_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_all("reset");

        bus_write(0, 8'h34, 3);
        check_all("freq lo only");
        bus_write(1, 8'h12, 3);
        check("freq 1234", 32'(freq0), 32'h1234);
        check_all("freq hi");

        bus_write(9, 8'hFF, 2);
        bus_write(10, 8'hAB, 4);
        check("pw BFF", 32'(pw1), 32'hBFF);
        bus_write(3, 8'h77, 2);
        check_all("pw and foreign addr");

        bus_write(4, 8'h41, 2);
        bus_write(5, 8'h09, 2);
        bus_write(6, 8'hF0, 2);
        check("ctl 41", 32'(ctl0), 32'h41);
        check_all("ctl ad sr");

        bus_read(4, 10);
        check_all("read");

        bus_write(1, 8'h56, 1);
        check_all("short pulse");

        // Reset while a FREQ_HI write is in progress.
        @(negedge clk);
        addr = 5'd1; rw = 1'b0; data_in = 8'h9A;
        #2 cs_n = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (10) @(negedge clk);
        check_all("reset mid access");

        bus_write(0, 8'hCD, 2);
        bus_write(1, 8'hAB, 2);
        check("freq after reset", 32'(freq0), 32'hABCD);
        check_all("after reset");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) bus_read($urandom_range(0, 20), $urandom_range(7, 10));
            else bus_write($urandom_range(0, 20), 8'($urandom), $urandom_range(1, 6));
            check_all($sformatf("rand %0d", i));
        end

        check("no double update v0", 32'(dbl_upd[0]), 32'd0);
        check("no double update v1", 32'(dbl_upd[1]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
